// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU normalise/round block.
package fpu_pkg;

  localparam int unsigned CExpLen  = 8;
  localparam int unsigned CFracLen = 23;
  localparam int unsigned CBias    = 127;

  // Bit positions inside AFlags = {overflow, underflow, inexact}
  localparam int unsigned FlagOvf = 2;
  localparam int unsigned FlagUfl = 1;
  localparam int unsigned FlagInx = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_rne_round.sv
// Combinational round-to-nearest-even, exponent fix-up and exception flags.
// Macro FPU_NORM_DENORM_EN: when undefined, exp < 1 flushes to signed zero.
module fpu_rne_round #(
  parameter int unsigned CMantLen = 28,
  parameter int unsigned CExpLen  = fpu_pkg::CExpLen,
  parameter int unsigned CFracLen = fpu_pkg::CFracLen,
  parameter int unsigned CExpW    = CExpLen + 3
) (
  input  logic                       i_sign,
  input  logic [CMantLen:0]          i_mant,
  input  logic signed [CExpW-1:0]    i_exp,
  input  logic                       i_sticky,
  output logic [CExpLen+CFracLen:0]  o_result_c,
  output logic [2:0]                 o_flags_c
);
  import fpu_pkg::*;

  localparam logic signed [CExpW-1:0] ExpOne = CExpW'(1);
  localparam logic signed [CExpW-1:0] ExpMax = CExpW'((1 << CExpLen) - 1);

  logic [CFracLen-1:0]     w_frac;
  logic [CFracLen-1:0]     w_frac_r;
  logic                    w_carry;
  logic                    w_guard;
  logic                    w_sticky;
  logic                    w_inc;
  logic                    w_hidden;
  logic                    w_inexact;
  logic                    w_zero;
  logic signed [CExpW-1:0] w_exp_f;

  assign w_frac    = i_mant[CMantLen-1 -: CFracLen];
  assign w_guard   = i_mant[CMantLen-CFracLen-1];
  assign w_sticky  = i_sticky | (|i_mant[CMantLen-CFracLen-2:0]);
  assign w_inc     = w_guard & (w_sticky | w_frac[0]);
  assign w_hidden  = i_mant[CMantLen];
  assign w_inexact = w_guard | w_sticky;
  assign w_zero    = (i_mant == '0) && !i_sticky;

  assign {w_carry, w_frac_r} = {1'b0, w_frac} + (CFracLen+1)'(w_inc);

  // Carry out of a normal bumps the exponent; a carry out of a denormal lands on the minimum normal.
  assign w_exp_f = w_hidden ? (i_exp + CExpW'(w_carry)) : (w_carry ? ExpOne : '0);

  // Select final encoding and flags, exceptional cases override the plain rounded value.
  always_comb begin
    o_result_c         = {i_sign, w_exp_f[CExpLen-1:0], w_frac_r};
    o_flags_c          = '0;
    o_flags_c[FlagInx] = w_inexact;
    o_flags_c[FlagUfl] = w_inexact && (w_exp_f == '0);
    if (w_zero) begin
      o_result_c = {i_sign, (CExpLen+CFracLen)'(0)};
      o_flags_c  = '0;
    end
`ifndef FPU_NORM_DENORM_EN
    else if (i_exp < ExpOne) begin
      o_result_c         = {i_sign, (CExpLen+CFracLen)'(0)};
      o_flags_c          = '0;
      o_flags_c[FlagUfl] = 1'b1;
      o_flags_c[FlagInx] = 1'b1;
    end
`endif
    else if (w_exp_f >= ExpMax) begin
      o_result_c         = {i_sign, {CExpLen{1'b1}}, {CFracLen{1'b0}}};
      o_flags_c          = '0;
      o_flags_c[FlagOvf] = 1'b1;
      o_flags_c[FlagInx] = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_norm_round.sv
// Normalise a multiplier product over several cycles, then round and pack it.
// Macro FPU_NORM_DENORM_EN: enables gradual underflow (right shifting while exp < 1).
module fpu_norm_round #(
  parameter int unsigned CMantLen = 28,
  parameter int unsigned CExpLen  = fpu_pkg::CExpLen,
  parameter int unsigned CFracLen = fpu_pkg::CFracLen
) (
  input  logic                      AClkH,
  input  logic                      AResetH,
  input  logic                      AClkHEn,
  input  logic                      AStart,
  input  logic [CMantLen+1:0]       ADataM,
  input  logic [CExpLen+1:0]        AExp,
  input  logic                      ASign,
  output logic [CExpLen+CFracLen:0] AResult,
  output logic [2:0]                AFlags,
  output logic                      AValid,
  output logic                      ABusy
);
  import fpu_pkg::*;

  localparam int unsigned MW = CMantLen + 2;
  localparam int unsigned EW = CExpLen + 3;
  localparam int unsigned RW = CExpLen + CFracLen + 1;
  localparam logic signed [EW-1:0] ExpOne = EW'(1);

  state_t              r_state, w_state_nxt;
  logic [MW-1:0]       r_mant, w_mant_nxt;
  logic signed [EW-1:0] r_exp, w_exp_nxt;
  logic                r_sign, w_sign_nxt;
  logic                r_sticky, w_sticky_nxt;
  logic [RW-1:0]       r_result, w_result_nxt;
  logic [2:0]          r_flags, w_flags_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy;

  logic [2:0]           w_lz4;
  logic                 w_lz5;
  logic signed [EW-1:0] w_exp_m1;
  logic signed [EW-1:0] w_one_m_exp;
  logic [2:0]           w_lsh;
  logic [2:0]           w_rsh;
  logic [MW-1:0]        w_mant_shr;
  logic                 w_shr_lost;
  logic [RW-1:0]        w_rnd_result;
  logic [2:0]           w_rnd_flags;

  // Shift amounts for one normalisation step, capped at 4 bits per cycle.
  always_comb begin
    w_lz4 = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (r_mant[CMantLen - i]) w_lz4 = 3'(i);
    end
    w_lz5       = (r_mant[CMantLen -: 5] == '0);
    w_exp_m1    = r_exp - ExpOne;
    w_one_m_exp = ExpOne - r_exp;
    w_lsh       = (w_exp_m1 < EW'(w_lz4)) ? w_exp_m1[2:0] : w_lz4;
    w_rsh       = (w_one_m_exp > EW'(4)) ? 3'd4 : w_one_m_exp[2:0];
    w_mant_shr  = r_mant >> w_rsh;
    w_shr_lost  = |(r_mant & ((MW'(1) << w_rsh) - MW'(1)));
  end

  fpu_rne_round #(
    .CMantLen (CMantLen),
    .CExpLen  (CExpLen),
    .CFracLen (CFracLen),
    .CExpW    (EW)
  ) u_round (
    .i_sign     (r_sign),
    .i_mant     (r_mant[CMantLen:0]),
    .i_exp      (r_exp),
    .i_sticky   (r_sticky),
    .o_result_c (w_rnd_result),
    .o_flags_c  (w_rnd_flags)
  );

  // State register.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH)      r_state <= IDLE;
    else if (AClkHEn) r_state <= w_state_nxt;
  end

  // Next state and datapath; a step leaves NORM in the same cycle when no further step is needed.
  always_comb begin
    w_state_nxt  = r_state;
    w_mant_nxt   = r_mant;
    w_exp_nxt    = r_exp;
    w_sign_nxt   = r_sign;
    w_sticky_nxt = r_sticky;
    w_result_nxt = '0;
    w_flags_nxt  = '0;
    w_valid_nxt  = 1'b0;
    case (r_state)
      IDLE: ;
      NORM: begin
        if (r_mant == '0) begin
          w_state_nxt = ROUND;
        end else if (r_mant[CMantLen+1]) begin
          w_mant_nxt   = r_mant >> 1;
          w_exp_nxt    = r_exp + ExpOne;
          w_sticky_nxt = r_sticky | r_mant[0];
`ifdef FPU_NORM_DENORM_EN
          if (!r_exp[EW-1]) w_state_nxt = ROUND;
`else
          w_state_nxt  = ROUND;
`endif
        end
`ifdef FPU_NORM_DENORM_EN
        else if (r_exp < ExpOne) begin
          w_mant_nxt   = w_mant_shr;
          w_sticky_nxt = r_sticky | w_shr_lost;
          if (w_mant_shr == '0) begin
            w_exp_nxt   = ExpOne;
            w_state_nxt = ROUND;
          end else begin
            w_exp_nxt = r_exp + EW'(w_rsh);
            if (w_one_m_exp <= EW'(4)) w_state_nxt = ROUND;
          end
        end
`endif
        else if (!r_mant[CMantLen] && (r_exp > ExpOne)) begin
          w_mant_nxt = r_mant << w_lsh;
          w_exp_nxt  = r_exp - EW'(w_lsh);
          if (!w_lz5 || (w_exp_m1 <= EW'(4))) w_state_nxt = ROUND;
        end else begin
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        w_result_nxt = w_rnd_result;
        w_flags_nxt  = w_rnd_flags;
        w_valid_nxt  = 1'b1;
        w_state_nxt  = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (AStart) begin
      w_mant_nxt   = ADataM;
      w_exp_nxt    = EW'($signed(AExp));
      w_sign_nxt   = ASign;
      w_sticky_nxt = 1'b0;
      w_result_nxt = '0;
      w_flags_nxt  = '0;
      w_valid_nxt  = 1'b0;
      w_state_nxt  = NORM;
    end
  end

  // Datapath and output registers, frozen while the clock enable is low.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (AClkHEn) begin
      r_mant   <= w_mant_nxt;
      r_exp    <= w_exp_nxt;
      r_sign   <= w_sign_nxt;
      r_sticky <= w_sticky_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  assign AResult = r_result;
  assign AFlags  = r_flags;
  assign AValid  = r_valid;
  assign ABusy   = r_busy;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed bench for fpu_norm_round (CMantLen=28, CExpLen=8, CFracLen=23).
module tb_fpu_norm_round;

  typedef struct {
    logic [29:0] data;
    logic [9:0]  exp;
    logic        sign;
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  logic        AClkH = 1'b0;
  logic        AResetH;
  logic        AClkHEn;
  logic        AStart;
  logic [29:0] ADataM;
  logic [9:0]  AExp;
  logic        ASign;
  logic [31:0] AResult;
  logic [2:0]  AFlags;
  logic        AValid;
  logic        ABusy;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_norm_round #(.CMantLen(28), .CExpLen(8), .CFracLen(23)) dut (
    .AClkH   (AClkH),
    .AResetH (AResetH),
    .AClkHEn (AClkHEn),
    .AStart  (AStart),
    .ADataM  (ADataM),
    .AExp    (AExp),
    .ASign   (ASign),
    .AResult (AResult),
    .AFlags  (AFlags),
    .AValid  (AValid),
    .ABusy   (ABusy)
  );

  always #5 AClkH = ~AClkH;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_result"}, AResult, 32'h0);
    chk({name, "_flags"}, 32'(AFlags), 32'h0);
    chk({name, "_valid"}, 32'(AValid), 32'h0);
    chk({name, "_busy"}, 32'(ABusy), 32'h0);
  endtask

  // Pulse AStart with one vector and check result, flags, latency and strobe width.
  task automatic run_vec(input vec_t v, input string name);
    int n;
    bit got;
    ADataM = v.data;
    AExp   = v.exp;
    ASign  = v.sign;
    AStart = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        AStart = 1'b0;
        chk({name, "_busy"}, 32'(ABusy), 32'h1);
      end
      if (AValid) got = 1'b1;
    end
    chk({name, "_valid_seen"}, 32'(got), 32'h1);
    chk({name, "_latency"}, 32'(n), 32'(v.lat));
    chk({name, "_result"}, AResult, v.res);
    chk({name, "_flags"}, 32'(AFlags), 32'(v.flags));
    tick();
    chk({name, "_strobe_end"}, 32'(AValid), 32'h0);
    chk({name, "_result_clr"}, AResult, 32'h0);
    chk({name, "_busy_end"}, 32'(ABusy), 32'h0);
  endtask

  initial begin
    vec_t vecs[$];
    int   n;
    int   nv;
    bit   got;
    logic [31:0] first_res;

    // data, exp, sign, result, {ovf,ufl,inx}, latency
    vecs.push_back('{30'h1000_0000, 10'd127, 1'b0, 32'h3F80_0000, 3'b000, 3});
    vecs.push_back('{30'h2000_0000, 10'd127, 1'b0, 32'h4000_0000, 3'b000, 3});
    vecs.push_back('{30'h1000_0010, 10'd127, 1'b0, 32'h3F80_0000, 3'b001, 3});
    vecs.push_back('{30'h1000_0030, 10'd127, 1'b0, 32'h3F80_0002, 3'b001, 3});
    vecs.push_back('{30'h0001_0000, 10'd140, 1'b0, 32'h4000_0000, 3'b000, 5});
    vecs.push_back('{30'h1000_0000, 10'd255, 1'b0, 32'h7F80_0000, 3'b101, 3});
    vecs.push_back('{30'h0000_0000, 10'd127, 1'b1, 32'h8000_0000, 3'b000, 3});
    vecs.push_back('{30'h1FFF_FFF0, 10'd127, 1'b0, 32'h4000_0000, 3'b001, 3});
    vecs.push_back('{30'h1800_0000, 10'd128, 1'b1, 32'hC040_0000, 3'b000, 3});
    vecs.push_back('{30'h0100_0000, 10'd3,   1'b0, 32'h0020_0000, 3'b000, 3});
    vecs.push_back('{30'h1000_0018, 10'd127, 1'b0, 32'h3F80_0001, 3'b001, 3});
    vecs.push_back('{30'h2000_0001, 10'd127, 1'b0, 32'h4000_0000, 3'b001, 3});
    vecs.push_back('{30'h1FFF_FFF0, 10'd254, 1'b0, 32'h7F80_0000, 3'b101, 3});
    vecs.push_back('{30'h0000_0000, 10'd255, 1'b0, 32'h0000_0000, 3'b000, 3});
`ifdef FPU_NORM_DENORM_EN
    vecs.push_back('{30'h1000_0000, 10'h3FF, 1'b0, 32'h0020_0000, 3'b000, 3});
    vecs.push_back('{30'h1FFF_FFF0, 10'h000, 1'b0, 32'h0080_0000, 3'b001, 3});
    vecs.push_back('{30'h1000_0000, 10'h3E2, 1'b0, 32'h0000_0000, 3'b011, 10});
`else
    vecs.push_back('{30'h1000_0000, 10'h3FF, 1'b0, 32'h0000_0000, 3'b011, 3});
    vecs.push_back('{30'h1FFF_FFF0, 10'h000, 1'b0, 32'h0000_0000, 3'b011, 3});
    vecs.push_back('{30'h1000_0000, 10'h3E2, 1'b1, 32'h8000_0000, 3'b011, 3});
`endif

    AResetH = 1'b1;
    AClkHEn = 1'b1;
    AStart  = 1'b0;
    ADataM  = '0;
    AExp    = '0;
    ASign   = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    AResetH = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while normalising clears everything at once.
    ADataM = 30'h0001_0000; AExp = 10'd140; ASign = 1'b1; AStart = 1'b1;
    tick();
    AStart = 1'b0;
    tick();
    chk("midreset_busy_before", 32'(ABusy), 32'h1);
    AResetH = 1'b1;
    #1;
    chk_idle("midreset_async");
    tick();
    chk_idle("midreset_next");
    AResetH = 1'b0;
    run_vec(vecs[0], "after_reset");

    // Restart while normalising: only the second operation is strobed.
    ADataM = 30'h0001_0000; AExp = 10'd140; ASign = 1'b0; AStart = 1'b1;
    tick();
    ADataM = 30'h1000_0030; AExp = 10'd127;
    tick();
    AStart = 1'b0;
    n = 1; nv = 0; got = 1'b0; first_res = '0;
    while (n < 15) begin
      if (AValid) begin
        if (!got) begin
          got = 1'b1;
          chk("restart_latency", 32'(n), 32'd3);
          first_res = AResult;
        end
        nv++;
      end
      tick();
      n++;
    end
    chk("restart_valid_seen", 32'(got), 32'h1);
    chk("restart_result", first_res, 32'h3F80_0002);
    chk("restart_strobe_count", 32'(nv), 32'd1);

    // Clock enable low holds the strobe and stretches latency.
    ADataM = 30'h1000_0030; AExp = 10'd127; ASign = 1'b0; AStart = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        AStart  = 1'b0;
        AClkHEn = 1'b0;
      end
      if (n == 3) AClkHEn = 1'b1;
      if (AValid) got = 1'b1;
    end
    chk("en_gap_latency", 32'(n), 32'd5);
    AClkHEn = 1'b0;
    repeat (3) tick();
    chk("en_hold_valid", 32'(AValid), 32'h1);
    chk("en_hold_result", AResult, 32'h3F80_0002);
    chk("en_hold_flags", 32'(AFlags), 32'h1);
    AClkHEn = 1'b1;
    tick();
    chk("en_resume_valid", 32'(AValid), 32'h0);
    chk("en_resume_result", AResult, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
